// File: rtl/mem_access_unit.sv
// Registered MEM stage: decodes load/store size, drives a word-lane bus with
// req/ack handshake, stalls EX while a transaction is outstanding and reports
// misaligned, illegal-size and faulting (bus error or timeout) accesses.
//
// state  | meaning
// IDLE   | ready to accept an instruction from EX; no bus request outstanding
// BUSY   | bus request held stable, waiting for mem_ack or timeout
module mem_access_unit #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic [XLEN-1:0]     i_rs_2,
  input  logic [4:0]          i_rd_num,
  input  logic [XLEN-1:0]     i_alu_out,
  input  logic [6:0]          i_opcode,
  input  logic [2:0]          i_func_3,
  input  logic                i_op_type,
  output logic                o_stall,
  output logic                o_valid,
  output logic [XLEN-1:0]     mem_out,
  output logic [4:0]          rd_num,
  output logic [XLEN-1:0]     alu_out,
  output logic                op_type,
  output logic [1:0]          o_exc,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_be,
  input  logic                mem_ack,
  input  logic [XLEN-1:0]     mem_rdata,
  input  logic                mem_err
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] EXC_NONE  = 2'b00;
  localparam logic [1:0] EXC_MISAL = 2'b01;
  localparam logic [1:0] EXC_FAULT = 2'b10;
  localparam logic [1:0] EXC_SIZE  = 2'b11;

  logic [0:0]       state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [2:0]       r_func_3;
  logic [OFF_W-1:0] r_off;
  logic             r_load;
  logic [4:0]       r_rd;

  logic             is_load;
  logic             is_store;
  logic             size_bad;
  logic             misal;
  logic [1:0]       sz;
  logic [2:0]       amask;
  logic [7:0]       mask8;
  logic [OFF_W-1:0] off;
  logic [BE_W-1:0]  be_n;
  logic [XLEN-1:0]  addr_al;
  logic [XLEN-1:0]  wdata_n;
  logic [XLEN-1:0]  shifted;
  logic [XLEN-1:0]  ld_data;

  assign o_stall = (state == S_BUSY);

  // Decode size, alignment and bus lane controls from the EX-stage inputs
  always_comb begin
    is_load  = (i_opcode == OP_LOAD);
    is_store = (i_opcode == OP_STORE);
    sz       = i_func_3[1:0];
    off      = i_alu_out[OFF_W-1:0];
    size_bad = 1'b0;
    if (is_load && i_func_3 == 3'd7) size_bad = 1'b1;
    if (is_store && i_func_3[2]) size_bad = 1'b1;
    // Doubleword and LWU only exist on RV64
    if (XLEN == 32 && (sz == 2'd3 || i_func_3 == 3'd6)) size_bad = 1'b1;
    amask = 3'b111 >> (2'd3 - sz);
    misal = (i_alu_out[2:0] & amask) != 3'b000;
    case (sz)
      2'd0:    mask8 = 8'h01;
      2'd1:    mask8 = 8'h03;
      2'd2:    mask8 = 8'h0F;
      default: mask8 = 8'hFF;
    endcase
    be_n    = BE_W'(mask8) << off;
    addr_al = {i_alu_out[XLEN-1:OFF_W], OFF_W'(0)};
    wdata_n = i_rs_2 << {off, 3'b000};
  end

  // Steer the returned lane down to bit 0 and extend to XLEN
  always_comb begin
    shifted = mem_rdata >> {r_off, 3'b000};
    case (r_func_3)
      3'd0:    ld_data = XLEN'($signed(shifted[7:0]));
      3'd1:    ld_data = XLEN'($signed(shifted[15:0]));
      3'd2:    ld_data = XLEN'($signed(shifted[31:0]));
      3'd3:    ld_data = shifted;
      3'd4:    ld_data = XLEN'(shifted[7:0]);
      3'd5:    ld_data = XLEN'(shifted[15:0]);
      3'd6:    ld_data = XLEN'(shifted[31:0]);
      default: ld_data = '0;
    endcase
  end

  // IDLE/BUSY sequencing, bus request registers and WB result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      tmo_cnt   <= '0;
      r_func_3  <= '0;
      r_off     <= '0;
      r_load    <= 1'b0;
      r_rd      <= '0;
      o_valid   <= 1'b0;
      mem_out   <= '0;
      rd_num    <= '0;
      alu_out   <= '0;
      op_type   <= 1'b0;
      o_exc     <= EXC_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_valid) begin
            alu_out  <= i_alu_out;
            op_type  <= i_op_type;
            r_func_3 <= i_func_3;
            r_off    <= off;
            r_load   <= is_load;
            r_rd     <= i_rd_num;
            if (!(is_load || is_store)) begin
              o_valid <= 1'b1;
              rd_num  <= i_rd_num;
              mem_out <= '0;
              o_exc   <= EXC_NONE;
            end else if (size_bad) begin
              o_valid <= 1'b1;
              rd_num  <= '0;
              mem_out <= '0;
              o_exc   <= EXC_SIZE;
            end else if (misal) begin
              o_valid <= 1'b1;
              rd_num  <= '0;
              mem_out <= '0;
              o_exc   <= EXC_MISAL;
            end else begin
              state     <= S_BUSY;
              tmo_cnt   <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_store;
              mem_addr  <= ADDR_W'(addr_al);
              mem_be    <= be_n;
              mem_wdata <= is_store ? wdata_n : '0;
            end
          end
        end
        S_BUSY: begin
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            o_valid <= 1'b1;
            if (mem_err) begin
              o_exc   <= EXC_FAULT;
              rd_num  <= '0;
              mem_out <= '0;
            end else begin
              o_exc   <= EXC_NONE;
              rd_num  <= r_load ? r_rd : 5'd0;
              mem_out <= r_load ? ld_data : '0;
            end
          end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            o_valid <= 1'b1;
            o_exc   <= EXC_FAULT;
            rd_num  <= '0;
            mem_out <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised, registered memory-access (MEM) stage for the RISC-V pipeline, replacing the purely combinational load/store stage. It sits between EX and WB and drives a word-lane memory bus with a req/ack handshake, byte enables and lane steering. It stalls the pipeline while a bus transaction is outstanding and flags misaligned, illegal and faulting accesses. It supports XLEN=32 (RV32I) and XLEN=64 (adds LD/LWU/SD).

Parameters:
XLEN, 32, datapath/bus width in bits; legal values are 32 and 64.
ADDR_W, 32, width of the memory bus address.
TIMEOUT, 16, number of BUSY cycles without mem_ack before the access is aborted as a fault; must be at least 2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_valid  in  1  EX output holds a valid instruction
i_rs_2  in  XLEN  store data
i_rd_num  in  5  destination register
i_alu_out  in  XLEN  effective address or ALU result
i_opcode  in  7  instruction opcode; LOAD=7'b0000011, STORE=7'b0100011
i_func_3  in  3  access size/sign
i_op_type  in  1  passed through to WB
o_stall  out  1  hold EX/upstream stages
o_valid  out  1  WB outputs valid this cycle
mem_out  out  XLEN  extended load data
rd_num  out  5  WB destination; 0 for stores and faults
alu_out  out  XLEN  registered copy of i_alu_out
op_type  out  1  registered copy of i_op_type
o_exc  out  2  00 none, 01 misaligned, 10 access fault (mem_err or timeout), 11 illegal size
mem_req  out  1  bus request
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  lane-aligned address (low log2(XLEN/8) bits zero)
mem_wdata  out  XLEN  lane-steered store data
mem_be  out  XLEN/8  byte enables
mem_ack  in  1  transaction complete; single-cycle pulse
mem_rdata  in  XLEN  full-lane read data, valid with mem_ack
mem_err  in  1  bus error, qualified by mem_ack

Behaviour:
- Reset (async, active-high): state IDLE, timeout counter 0, every output 0.
- FSM states: IDLE, BUSY. o_stall = (state==BUSY), combinational.
- Accept: in IDLE with i_valid=1, all inputs are captured at the clock edge.
- Non-memory opcode: the next cycle shows o_valid=1, rd_num=i_rd_num, alu_out, op_type, mem_out=0, o_exc=00. FSM stays IDLE. Latency is 1 cycle.
- Size decode:
  - func_3 LB/SB=0, LH/SH=1, LW/SW=2, LD/SD=3, LBU=4, LHU=5, LWU=6; giving 1, 2, 4 and 8 bytes.
  - Illegal size: func_3=7 for a load; func_3≥4 for a store; 3 or 6 when XLEN=32.
  - An illegal size gives o_exc=11 next cycle with o_valid=1, rd_num=0, mem_out=0, and no bus request.
- Misaligned (addr mod size ≠ 0): o_exc=01 next cycle, o_valid=1, rd_num=0, no request.
- Aligned load or store: next cycle state is BUSY, o_valid=0, and the following are registered and held stable until ack:
  - mem_req=1
  - mem_we = STORE
  - mem_addr = addr with offset bits cleared, truncated/zero-extended to ADDR_W
  - mem_be = ((1<<size)-1) << offset
  - mem_wdata = rs_2 << (8*offset); loads drive mem_wdata=0
- BUSY, mem_ack=1, mem_err=0: the next cycle shows IDLE, mem_req=0, o_valid=1.
  - Load: data = mem_rdata >> (8*offset), then sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU) from size to XLEN; LD takes the full 64 bits.
  - Store: rd_num=0, mem_out=0.
- BUSY, mem_ack=1, mem_err=1: same timing as a normal ack, but o_exc=10, rd_num=0, mem_out=0.
- Timeout counter:
  - Clears on accept and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT-1 with no ack, the next cycle is IDLE with mem_req=0, o_valid=1, o_exc=10, rd_num=0.
  - A mem_ack arriving in that same cycle wins (normal completion).
- Minimum aligned access: 1 cycle in BUSY; the result appears 2 cycles after accept.
- o_valid is a 1-cycle pulse per completed instruction and is 0 otherwise.
- i_valid is ignored while BUSY; upstream holds its instruction under o_stall. The upstream instruction is accepted in the cycle the FSM returns to IDLE.
- mem_ack while IDLE is ignored.
- Reset during BUSY aborts immediately: mem_req drops asynchronously and no o_valid is produced.

Test Plan:
- XLEN=32; ADD passthrough with alu_out=0x1234, rd=5 -> o_valid=1 one cycle later, rd_num=5, alu_out=0x1234, no mem_req.
- LB addr=0x1003; ack after 3 cycles with rdata=0x80AABBCC -> mem_addr=0x1000, mem_be=4'b1000, o_stall high 3 cycles, mem_out=0xFFFFFF80; LBU of the same -> 0x00000080.
- SH addr=0x2002, rs_2=0xDEADBEEF -> mem_we=1, mem_be=4'b1100, mem_wdata=0xBEEF0000, rd_num=0 on completion.
- LW addr=0x2002 -> o_exc=01, no mem_req, o_valid next cycle; SD with XLEN=32 -> o_exc=11.
- LW with no ack for TIMEOUT=16 cycles -> mem_req drops after 16 BUSY cycles, o_exc=10; repeat with mem_err=1 on ack -> o_exc=10, rd_num=0.
- XLEN=64: LWU addr=0x4, rdata=0xF0000000_00000000 -> mem_be=8'hF0, mem_out=0x00000000_F0000000; assert rst mid-BUSY -> all outputs 0 immediately.
